i2c_master_byte: RTL
====================

# i2c_master_byte

Single-register I2C master for configuring the BT656 video decoder from the board's key/switch front end. It captures a transaction request (`start`, `read`, `reg_dest`, `data_to_send`) from the manual input stage and runs one complete I2C transaction on open-drain SCL/SDA. A write is 3 bytes; a read uses a repeated-start and returns one byte on `rd_data`. It reports completion and slave NACK back to the front end for display.

## Interface
- `DEV_ADDR`, 7'h21, 7-bit slave address; the R/W bit is appended as the LSB.
- `CLK_DIV`, 125, number of `clk` cycles per quarter SCL period. At 50 MHz this gives 100 kHz. Legal range is 2..4095.
- `clk`  input  1  system clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  active-low request; idles high. A transaction begins when `start` is sampled 1 then 0 on consecutive cycles.
- `read`  input  1  1 = register read, 0 = register write. Latched on the start edge.
- `reg_dest`  input  8  register address. Latched on the start edge.
- `data_to_send`  input  8  write data. Latched on the start edge; ignored for reads.
- `sda_in`  input  1  sampled SDA pad level.
- `scl_oe`  output  1  1 = pull SCL low; 0 = release.
- `sda_oe`  output  1  1 = pull SDA low; 0 = release.
- `busy`  output  1  high from the cycle after the start edge until the transaction ends.
- `done`  output  1  one-cycle pulse at transaction end, including aborts.
- `ack_err`  output  1  sticky: slave NACKed any byte in the last transaction. Cleared on the next start edge.
- `rd_data`  output  8  last byte read. Holds its value until the next successful read.

## Operation
- All outputs reset to 0. `scl_oe`=0 and `sda_oe`=0, so both lines are released.
- Tick generator:
  - Counts 0..CLK_DIV-1 while `busy`; one tick per wrap.
  - Held at 0 while idle.
- Bit-time structure: 4 ticks per bit, phases Q0..Q3.
  - Q0: SCL low; drive the new SDA value.
  - Q1 and Q2: SCL released (high).
  - `sda_in` is sampled on the first cycle of Q2.
  - Q3: SCL low.
- States: IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP.
  - IDLE -> START on a start edge; all request inputs are latched.
  - START: SDA low during Q1–Q2 while SCL is high; SCL low at Q3.
  - TX_BYTE: 8 bits, MSB first. A 0 bit is driven with `sda_oe`=1; a 1 bit with `sda_oe`=0.
  - RX_ACK: SDA released for one bit-time.
    - `sda_in`=1 at the sample point -> set `ack_err`, go to STOP.
    - Otherwise advance to the next byte.
  - Write sequence: {DEV_ADDR,0}, reg_dest, data_to_send, then STOP.
  - Read sequence: {DEV_ADDR,0}, reg_dest, RSTART, {DEV_ADDR,1}, RX_BYTE, TX_NACK, STOP.
  - RSTART: SDA released Q0–Q1, pulled low in Q2 while SCL is high, SCL low at Q3.
  - RX_BYTE: SDA released; 8 samples shifted MSB first. `rd_data` is updated only after the master NACK bit.
  - TX_NACK: SDA released for one bit-time.
  - STOP: SDA low Q0–Q1; SCL high Q1–Q3; SDA released at Q3.
  - After STOP: return to IDLE, deassert `busy`, pulse `done` in the same cycle.
- A start edge while `busy` is ignored.
- `reset` mid-transaction:
  - Next cycle: `scl_oe`=`sda_oe`=0, state IDLE, all outputs 0.
  - No STOP condition is generated.
- The SCL line is never driven high. SDA changes only while SCL is low, except in START, RSTART and STOP.

## Timing
- `busy` rises 1 cycle after the cycle where `start` is first sampled 0.
- Let B = 4·CLK_DIV cycles per bit-time. `busy` high duration:
  - write: (1 + 27 + 1)·B = 116·CLK_DIV
  - read: (1 + 18 + 1 + 18 + 1)·B = 156·CLK_DIV
  - NACK on byte k (1-based): (1 + 9k + 1)·B
- `done` coincides with the first cycle of `busy`=0.
- `rd_data` and `ack_err` are valid when `done` is high.
- SCL high time is 2·CLK_DIV; low time is 2·CLK_DIV.
- Slave clock stretching is not supported. SCL is not read back.

## Test plan
- Write, CLK_DIV=4, DEV_ADDR=7'h21, reg_dest=8'h0A, data_to_send=8'h3C; slave ACKs every byte.
  - Bus decodes START, 0x42, 0x0A, 0x3C, STOP.
  - `busy` high for 464 cycles; `done` pulses once; `ack_err`=0.
- Read, reg_dest=8'h10; slave ACKs and returns 8'hA5.
  - Bus decodes START, 0x42, 0x10, RSTART, 0x43, data, NACK, STOP.
  - `rd_data`=8'hA5; `busy` high for 624 cycles.
- Slave NACKs the address byte.
  - STOP follows directly after the first ACK slot.
  - `ack_err`=1; `busy` high for 176 cycles.
  - `rd_data` is unchanged.
- Start edge held low, plus a second start edge, both during `busy`.
  - Exactly one transaction runs and one `done` pulse is produced.
- Assert `reset` mid-TX_BYTE.
  - Next cycle: `scl_oe`=`sda_oe`=`busy`=0.
  - A subsequent start edge runs a full, correct write.
- `start` held low continuously after a transaction completes.
  - No new transaction starts until `start` returns high and falls again.

Source files
------------

// File: rtl/i2c_master_byte.sv
// Single-register I2C master: one START..STOP write (3 bytes) or a
// repeated-start register read on open-drain SCL/SDA.
module i2c_master_byte #(
    parameter logic [6:0]  DEV_ADDR = 7'h21,
    parameter int unsigned CLK_DIV  = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       read,
    input  logic [7:0] reg_dest,
    input  logic [7:0] data_to_send,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rd_data
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        TX_BYTE = 3'd2,
        RX_ACK  = 3'd3,
        RSTART  = 3'd4,
        RX_BYTE = 3'd5,
        TX_NACK = 3'd6,
        STOP    = 3'd7
    } state_t;

    localparam logic [11:0] CNT_MAX = 12'(CLK_DIV - 1);

    // Byte index 0..3 selects address-write, register, data, address-read.
    function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic [7:0] rg,
                                           input logic [7:0] dt);
        case (idx)
            2'd0:    tx_byte = {DEV_ADDR, 1'b0};
            2'd1:    tx_byte = rg;
            2'd2:    tx_byte = dt;
            default: tx_byte = {DEV_ADDR, 1'b1};
        endcase
    endfunction

    // Returns {scl_oe, sda_oe} for a given state and quarter phase.
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] ph, input logic txb);
        logic scl_low;
        scl_low = (ph == 2'd0) || (ph == 2'd3);
        case (st)
            IDLE:    bus_drive = 2'b00;
            START:   bus_drive = (ph == 2'd0) ? 2'b00 : ((ph == 2'd3) ? 2'b11 : 2'b01);
            TX_BYTE: bus_drive = {scl_low, ~txb};
            RX_ACK, RX_BYTE, TX_NACK: bus_drive = {scl_low, 1'b0};
            RSTART: begin
                case (ph)
                    2'd0:    bus_drive = 2'b10;
                    2'd1:    bus_drive = 2'b00;
                    2'd2:    bus_drive = 2'b01;
                    default: bus_drive = 2'b11;
                endcase
            end
            STOP:    bus_drive = (ph == 2'd0) ? 2'b11 : ((ph == 2'd3) ? 2'b00 : 2'b01);
            default: bus_drive = 2'b00;
        endcase
    endfunction

    state_t      state_r, state_n;
    logic [1:0]  phase_r, phase_n, idx_r, idx_n;
    logic [11:0] cnt_r, cnt_n;
    logic [2:0]  bit_r, bit_n;
    logic [7:0]  rx_r, rx_n, reg_r, reg_n, data_r, data_n, rd_data_r, rd_data_n;
    logic        read_r, read_n, start_d_r, busy_r, busy_n, done_r, done_n;
    logic        ack_err_r, ack_err_n, scl_oe_r, sda_oe_r;
    logic        tick_s, bit_end_s, sample_s, tx_bit_s;
    logic [7:0]  byte_s;
    logic [1:0]  drive_s;

    assign tick_s    = (cnt_r == CNT_MAX);
    assign bit_end_s = tick_s && (phase_r == 2'd3);
    assign sample_s  = (phase_r == 2'd2) && (cnt_r == 12'd0);
    // Line drive is computed from the next state so it lines up with busy.
    assign byte_s    = tx_byte(idx_n, reg_n, data_n);
    assign tx_bit_s  = byte_s[3'd7 - bit_n];
    assign drive_s   = bus_drive(state_n, phase_n, tx_bit_s);

    // State, bit timing and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            phase_r   <= 2'd0;
            idx_r     <= 2'd0;
            cnt_r     <= 12'd0;
            bit_r     <= 3'd0;
            rx_r      <= 8'd0;
            reg_r     <= 8'd0;
            data_r    <= 8'd0;
            read_r    <= 1'b0;
            start_d_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_err_r <= 1'b0;
            rd_data_r <= 8'd0;
            scl_oe_r  <= 1'b0;
            sda_oe_r  <= 1'b0;
        end else begin
            state_r   <= state_n;
            phase_r   <= phase_n;
            idx_r     <= idx_n;
            cnt_r     <= cnt_n;
            bit_r     <= bit_n;
            rx_r      <= rx_n;
            reg_r     <= reg_n;
            data_r    <= data_n;
            read_r    <= read_n;
            start_d_r <= start;
            busy_r    <= busy_n;
            done_r    <= done_n;
            ack_err_r <= ack_err_n;
            rd_data_r <= rd_data_n;
            scl_oe_r  <= drive_s[1];
            sda_oe_r  <= drive_s[0];
        end
    end

    // Next-state logic: quarter-phase sequencing and byte/bit progression.
    always_comb begin
        state_n   = state_r;
        phase_n   = phase_r;
        idx_n     = idx_r;
        bit_n     = bit_r;
        rx_n      = rx_r;
        reg_n     = reg_r;
        data_n    = data_r;
        read_n    = read_r;
        busy_n    = busy_r;
        done_n    = 1'b0;
        ack_err_n = ack_err_r;
        rd_data_n = rd_data_r;
        if (state_r == IDLE) begin
            cnt_n = 12'd0;
        end else if (tick_s) begin
            cnt_n   = 12'd0;
            phase_n = phase_r + 2'd1;
        end else begin
            cnt_n = cnt_r + 12'd1;
        end
        case (state_r)
            IDLE: begin
                if (start_d_r && !start) begin
                    state_n   = START;
                    phase_n   = 2'd0;
                    bit_n     = 3'd0;
                    idx_n     = 2'd0;
                    read_n    = read;
                    reg_n     = reg_dest;
                    data_n    = data_to_send;
                    busy_n    = 1'b1;
                    ack_err_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (bit_end_s) state_n = TX_BYTE;
                else           state_n = START;
            end
            TX_BYTE: begin
                if (bit_end_s && (bit_r == 3'd7)) begin
                    state_n = RX_ACK;
                    bit_n   = 3'd0;
                end else if (bit_end_s) begin
                    bit_n = bit_r + 3'd1;
                end else begin
                    bit_n = bit_r;
                end
            end
            RX_ACK: begin
                if (sample_s && sda_in) ack_err_n = 1'b1;
                else                    ack_err_n = ack_err_r;
                if (bit_end_s && ack_err_r) begin
                    state_n = STOP;
                end else if (bit_end_s) begin
                    case (idx_r)
                        2'd0: begin
                            state_n = TX_BYTE;
                            idx_n   = 2'd1;
                        end
                        2'd1: begin
                            state_n = read_r ? RSTART : TX_BYTE;
                            idx_n   = read_r ? 2'd3 : 2'd2;
                        end
                        2'd2:    state_n = STOP;
                        default: state_n = RX_BYTE;
                    endcase
                end else begin
                    state_n = RX_ACK;
                end
            end
            RSTART: begin
                if (bit_end_s) state_n = TX_BYTE;
                else           state_n = RSTART;
            end
            RX_BYTE: begin
                if (sample_s) rx_n = {rx_r[6:0], sda_in};
                else          rx_n = rx_r;
                if (bit_end_s && (bit_r == 3'd7)) begin
                    state_n = TX_NACK;
                    bit_n   = 3'd0;
                end else if (bit_end_s) begin
                    bit_n = bit_r + 3'd1;
                end else begin
                    bit_n = bit_r;
                end
            end
            TX_NACK: begin
                if (bit_end_s) begin
                    rd_data_n = rx_r;
                    state_n   = STOP;
                end else begin
                    state_n = TX_NACK;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n = STOP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign scl_oe  = scl_oe_r;
    assign sda_oe  = sda_oe_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign ack_err = ack_err_r;
    assign rd_data = rd_data_r;
endmodule
